pong_game_ctrl: RTL and testbench

//   Per-frame game-state controller for the pong design. On each frame tick from
//   the VGA timing block it advances ball and paddle positions, resolves wall and

---
 rtl/pong_game_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Per-frame pong game-state controller: advances ball and paddle on each frame
// tick, resolves wall/paddle collisions and sequences SERVE/PLAY/MISS.
module pong_game_ctrl #(
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned X_POS_W      = 10,
  parameter int unsigned Y_POS_W      = 9,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned PADDLE_X     = 16,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 30
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_tick_i,
  input  logic               key_up_i,
  input  logic               key_down_i,
  output logic [X_POS_W-1:0] ball_x_o,
  output logic [Y_POS_W-1:0] ball_y_o,
  output logic [Y_POS_W-1:0] paddle_y_o,
  output logic [7:0]         score_o,
  output logic [7:0]         miss_cnt_o,
  output logic [1:0]         state_o,
  output logic               update_o,
  output logic               led_o
);

  localparam int unsigned XW       = X_POS_W + 1;
  localparam int unsigned YW       = Y_POS_W + 1;
  localparam int unsigned MAX_FR   = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int unsigned CNT_W    = $clog2(MAX_FR + 1);

  localparam logic [XW-1:0] X_CTR  = XW'((H_RES - BALL_SIZE) / 2);
  localparam logic [XW-1:0] X_MAX  = XW'(H_RES - BALL_SIZE);
  localparam logic [XW-1:0] X_SPD  = XW'(BALL_SPEED);
  localparam logic [XW-1:0] FACE   = XW'(PADDLE_X + PADDLE_W);
  localparam logic [YW-1:0] Y_CTR  = YW'((V_RES - BALL_SIZE) / 2);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_RES - BALL_SIZE);
  localparam logic [YW-1:0] Y_SPD  = YW'(BALL_SPEED);
  localparam logic [YW-1:0] BALL_H = YW'(BALL_SIZE);
  localparam logic [YW-1:0] PAD_H  = YW'(PADDLE_H);
  localparam logic [YW-1:0] P_CTR  = YW'((V_RES - PADDLE_H) / 2);
  localparam logic [YW-1:0] P_MAX  = YW'(V_RES - PADDLE_H);
  localparam logic [YW-1:0] P_SPD  = YW'(PADDLE_SPEED);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] MISS_LAST  = CNT_W'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [X_POS_W-1:0] ball_x_q, ball_x_nxt;
  logic [Y_POS_W-1:0] ball_y_q, ball_y_nxt;
  logic [Y_POS_W-1:0] paddle_q, paddle_nxt, pad_mv;
  logic [7:0]         score_q, score_nxt;
  logic [7:0]         miss_q, miss_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               dx_q, dx_nxt;           // 1 = moving right
  logic               dy_q, dy_nxt;           // 1 = moving down
  logic               serve_dir_q, serve_dir_nxt;
  logic               update_q, update_nxt;
  logic               led_q, led_nxt;

  logic [XW-1:0] bx_w;
  logic [YW-1:0] by_w;
  logic [YW-1:0] pad_w;
  logic          hit_c;
  logic          lost_c;

  assign bx_w  = {1'b0, ball_x_q};
  assign by_w  = {1'b0, ball_y_q};
  assign pad_w = {1'b0, paddle_q};

  // Collision flags use this frame's pre-move ball and paddle positions
  always_comb begin
    hit_c  = !dx_q && (bx_w >= FACE) && (bx_w <= FACE + X_SPD) &&
             (by_w + BALL_H > pad_w) && (by_w < pad_w + PAD_H);
    lost_c = !dx_q && !hit_c && (bx_w <= X_SPD);
  end

  // Paddle step with clamping to the visible area
  always_comb begin
    pad_mv = paddle_q;
    if (key_up_i && !key_down_i) begin
      pad_mv = (pad_w <= P_SPD) ? '0 : Y_POS_W'(pad_w - P_SPD);
    end else if (key_down_i && !key_up_i) begin
      pad_mv = (pad_w + P_SPD >= P_MAX) ? Y_POS_W'(P_MAX) : Y_POS_W'(pad_w + P_SPD);
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_SERVE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_SERVE: if (frame_tick_i && (cnt_q == SERVE_LAST)) state_nxt = ST_PLAY;
      ST_PLAY:  if (frame_tick_i && lost_c) state_nxt = ST_MISS;
      ST_MISS:  if (frame_tick_i && (cnt_q == MISS_LAST)) state_nxt = ST_SERVE;
      default:  state_nxt = ST_SERVE;
    endcase
  end

  // Datapath next values
  always_comb begin
    ball_x_nxt    = ball_x_q;
    ball_y_nxt    = ball_y_q;
    paddle_nxt    = paddle_q;
    score_nxt     = score_q;
    miss_nxt      = miss_q;
    cnt_nxt       = cnt_q;
    dx_nxt        = dx_q;
    dy_nxt        = dy_q;
    serve_dir_nxt = serve_dir_q;
    update_nxt    = frame_tick_i;
    led_nxt       = (state_nxt == ST_MISS);
    if (frame_tick_i) begin
      case (state_q)
        ST_SERVE: begin
          paddle_nxt = pad_mv;
          ball_x_nxt = X_POS_W'(X_CTR);
          ball_y_nxt = Y_POS_W'(Y_CTR);
          cnt_nxt    = (cnt_q == SERVE_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
        ST_PLAY: begin
          paddle_nxt = pad_mv;
          if (!dy_q) begin
            if (by_w <= Y_SPD) begin
              ball_y_nxt = '0;
              dy_nxt     = 1'b1;
            end else begin
              ball_y_nxt = Y_POS_W'(by_w - Y_SPD);
            end
          end else if (by_w + Y_SPD >= Y_MAX) begin
            ball_y_nxt = Y_POS_W'(Y_MAX);
            dy_nxt     = 1'b0;
          end else begin
            ball_y_nxt = Y_POS_W'(by_w + Y_SPD);
          end
          if (dx_q) begin
            if (bx_w + X_SPD >= X_MAX) begin
              ball_x_nxt = X_POS_W'(X_MAX);
              dx_nxt     = 1'b0;
            end else begin
              ball_x_nxt = X_POS_W'(bx_w + X_SPD);
            end
          end else if (hit_c) begin
            ball_x_nxt = X_POS_W'(FACE);
            dx_nxt     = 1'b1;
            score_nxt  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          end else if (lost_c) begin
            ball_x_nxt = '0;
            miss_nxt   = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
            cnt_nxt    = '0;
          end else begin
            ball_x_nxt = X_POS_W'(bx_w - X_SPD);
          end
        end
        ST_MISS: begin
          if (cnt_q == MISS_LAST) begin
            cnt_nxt       = '0;
            ball_x_nxt    = X_POS_W'(X_CTR);
            ball_y_nxt    = Y_POS_W'(Y_CTR);
            dx_nxt        = 1'b1;
            serve_dir_nxt = ~serve_dir_q;
            dy_nxt        = ~serve_dir_q;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_nxt    = '0;
          ball_x_nxt = X_POS_W'(X_CTR);
          ball_y_nxt = Y_POS_W'(Y_CTR);
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ball_x_q    <= X_POS_W'(X_CTR);
      ball_y_q    <= Y_POS_W'(Y_CTR);
      paddle_q    <= Y_POS_W'(P_CTR);
      score_q     <= '0;
      miss_q      <= '0;
      cnt_q       <= '0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      serve_dir_q <= 1'b1;
      update_q    <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      ball_x_q    <= ball_x_nxt;
      ball_y_q    <= ball_y_nxt;
      paddle_q    <= paddle_nxt;
      score_q     <= score_nxt;
      miss_q      <= miss_nxt;
      cnt_q       <= cnt_nxt;
      dx_q        <= dx_nxt;
      dy_q        <= dy_nxt;
      serve_dir_q <= serve_dir_nxt;
      update_q    <= update_nxt;
      led_q       <= led_nxt;
    end
  end

  assign ball_x_o   = ball_x_q;
  assign ball_y_o   = ball_y_q;
  assign paddle_y_o = paddle_q;
  assign score_o    = score_q;
  assign miss_cnt_o = miss_q;
  assign state_o    = state_q;
  assign update_o   = update_q;
  assign led_o      = led_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table, directed game sequences
// and randomized play compared against an integer game model.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       key_up;
  logic       key_down;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [8:0] paddle_y;
  logic [7:0] score;
  logic [7:0] miss_cnt;
  logic [1:0] state;
  logic       update;
  logic       led;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .frame_tick_i (frame_tick),
    .key_up_i     (key_up),
    .key_down_i   (key_down),
    .ball_x_o     (ball_x),
    .ball_y_o     (ball_y),
    .paddle_y_o   (paddle_y),
    .score_o      (score),
    .miss_cnt_o   (miss_cnt),
    .state_o      (state),
    .update_o     (update),
    .led_o        (led)
  );

  int checks = 0;
  int errors = 0;

  // Game model: signed directions, plain integer positions
  int m_bx, m_by, m_dx, m_dy, m_pad, m_score, m_miss, m_st, m_cnt, m_sdir;
  bit m_upd;

  task automatic m_reset();
    m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1; m_sdir = 1;
    m_pad = 208; m_score = 0; m_miss = 0; m_st = 0; m_cnt = 0; m_upd = 1'b0;
  endtask

  task automatic m_step(input bit u, input bit d);
    int opad;
    int oby;
    int nx;
    int ny;
    opad = m_pad;
    oby  = m_by;
    if (m_st != 2) begin
      if (u && !d) m_pad = (m_pad - 4 < 0) ? 0 : m_pad - 4;
      else if (d && !u) m_pad = (m_pad + 4 > 416) ? 416 : m_pad + 4;
    end
    case (m_st)
      0: begin
        m_cnt++;
        if (m_cnt == 60) begin m_st = 1; m_cnt = 0; end
      end
      1: begin
        ny = oby + 2 * m_dy;
        if (ny <= 0) begin ny = 0; m_dy = 1; end
        else if (ny >= 472) begin ny = 472; m_dy = -1; end
        if (m_dx > 0) begin
          nx = m_bx + 2;
          if (nx >= 632) begin nx = 632; m_dx = -1; end
        end else if (m_bx >= 24 && m_bx <= 26 && oby + 8 > opad && oby < opad + 64) begin
          nx = 24; m_dx = 1;
          if (m_score < 255) m_score++;
        end else if (m_bx <= 2) begin
          nx = 0; m_st = 2; m_cnt = 0;
          if (m_miss < 255) m_miss++;
        end else begin
          nx = m_bx - 2;
        end
        m_bx = nx;
        m_by = ny;
      end
      default: begin
        m_cnt++;
        if (m_cnt == 30) begin
          m_st = 0; m_cnt = 0; m_bx = 316; m_by = 236; m_dx = 1;
          m_sdir = -m_sdir; m_dy = m_sdir;
        end
      end
    endcase
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".ball_x"}, int'(ball_x), m_bx);
    chk({tag, ".ball_y"}, int'(ball_y), m_by);
    chk({tag, ".paddle"}, int'(paddle_y), m_pad);
    chk({tag, ".score"}, int'(score), m_score);
    chk({tag, ".miss"}, int'(miss_cnt), m_miss);
    chk({tag, ".state"}, int'(state), m_st);
    chk({tag, ".led"}, int'(led), (m_st == 2) ? 1 : 0);
    chk({tag, ".update"}, int'(update), int'(m_upd));
  endtask

  // One clock: drive at a falling edge, sample at the next falling edge
  task automatic cyc(input bit t, input bit u, input bit d);
    frame_tick = t;
    key_up     = u;
    key_down   = d;
    @(negedge clk);
    if (t) m_step(u, d);
    m_upd = t;
  endtask

  typedef struct {
    int n;
    bit up;
    bit dn;
    int pad;
    int st;
    int bx;
    int by;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int prev_bx;
    int play_ticks;
    bit u;
    bit d;

    tbl[0] = '{n: 52,  up: 1'b1, dn: 1'b0, pad: 0,   st: 0, bx: 316, by: 236};
    tbl[1] = '{n: 5,   up: 1'b1, dn: 1'b0, pad: 0,   st: 0, bx: 316, by: 236};
    tbl[2] = '{n: 3,   up: 1'b1, dn: 1'b1, pad: 0,   st: 1, bx: 316, by: 236};
    tbl[3] = '{n: 1,   up: 1'b0, dn: 1'b0, pad: 0,   st: 1, bx: 318, by: 238};
    tbl[4] = '{n: 104, up: 1'b0, dn: 1'b1, pad: 416, st: 1, bx: 526, by: 446};
    tbl[5] = '{n: 3,   up: 1'b0, dn: 1'b1, pad: 416, st: 1, bx: 532, by: 452};
    tbl[6] = '{n: 2,   up: 1'b0, dn: 1'b0, pad: 416, st: 1, bx: 536, by: 456};

    rst = 1'b1; frame_tick = 1'b0; key_up = 1'b0; key_down = 1'b0;
    m_reset();
    @(negedge clk);
    chk("rst.ball_x", int'(ball_x), 316);
    chk("rst.ball_y", int'(ball_y), 236);
    chk("rst.paddle", int'(paddle_y), 208);
    chk("rst.state", int'(state), 0);
    chk("rst.score", int'(score), 0);
    chk("rst.led", int'(led), 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk_model("idle");

    // Paddle sweep and serve-to-play, back-to-back ticks
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) cyc(1'b1, tbl[i].up, tbl[i].dn);
      chk($sformatf("tbl%0d.paddle", i), int'(paddle_y), tbl[i].pad);
      chk($sformatf("tbl%0d.state", i), int'(state), tbl[i].st);
      chk($sformatf("tbl%0d.ball_x", i), int'(ball_x), tbl[i].bx);
      chk($sformatf("tbl%0d.ball_y", i), int'(ball_y), tbl[i].by);
      chk_model($sformatf("tbl%0d", i));
    end

    // Outputs hold and update drops between ticks
    cyc(1'b0, 1'b1, 1'b0);
    chk("gap.update", int'(update), 0);
    chk_model("gap");
    cyc(1'b1, 1'b0, 1'b0);
    chk("single.update", int'(update), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("single.update_drop", int'(update), 0);

    // Wall bounces: 111 PLAY ticks taken so far
    play_ticks = 111;
    while (play_ticks < 160) begin
      cyc(1'b1, 1'b0, 1'b0);
      play_ticks++;
      if (play_ticks == 118) chk("wall.y472", int'(ball_y), 472);
      if (play_ticks == 119) chk("wall.y470", int'(ball_y), 470);
      if (play_ticks == 158) chk("wall.x632", int'(ball_x), 632);
      if (play_ticks == 159) chk("wall.x630", int'(ball_x), 630);
      chk_model("wall");
    end

    // Paddle tracks the ball until the first hit
    prev_bx = int'(ball_x);
    for (int i = 0; i < 2000 && m_score == 0; i++) begin
      prev_bx = int'(ball_x);
      u = (m_pad + 32 > m_by + 6);
      d = (m_pad + 32 < m_by + 2);
      cyc(1'b1, u, d);
      chk_model("track");
    end
    if (m_score == 0) chk("hit.timeout", 0, 1);
    else begin
      chk("hit.prev_x", prev_bx, 26);
      chk("hit.x", int'(ball_x), 24);
      chk("hit.score", int'(score), 1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("hit.rebound_x", int'(ball_x), 26);
    end

    // Paddle parked at the top until the ball slips past
    for (int i = 0; i < 6000 && m_st != 2; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (m_st != 2) chk_model("chase");
    end
    if (m_st != 2) chk("miss.timeout", 0, 1);
    else begin
      chk("miss.ball_x", int'(ball_x), 0);
      chk("miss.state", int'(state), 2);
      chk("miss.led", int'(led), 1);
      chk("miss.cnt", int'(miss_cnt), 1);
      chk("miss.paddle", int'(paddle_y), 0);
      for (int i = 0; i < 29; i++) begin
        cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk_model("miss_hold");
      end
      chk("miss.still", int'(state), 2);
      cyc(1'b1, 1'b0, 1'b1);
      chk("reserve.state", int'(state), 0);
      chk("reserve.ball_x", int'(ball_x), 316);
      chk("reserve.ball_y", int'(ball_y), 236);
      chk("reserve.led", int'(led), 0);
      for (int i = 0; i < 60; i++) cyc(1'b1, 1'b0, 1'b0);
      chk("reserve.play", int'(state), 1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("reserve.x", int'(ball_x), 318);
      chk("reserve.y_up", int'(ball_y), 234);
      chk_model("reserve");
    end

    // Asynchronous reset between edges, ticks ignored while held
    cyc(1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst.ball_x", int'(ball_x), 316);
    chk("arst.ball_y", int'(ball_y), 236);
    chk("arst.paddle", int'(paddle_y), 208);
    chk("arst.score", int'(score), 0);
    chk("arst.miss", int'(miss_cnt), 0);
    chk("arst.state", int'(state), 0);
    chk("arst.update", int'(update), 0);
    chk("arst.led", int'(led), 0);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    chk("arst.tick_update", int'(update), 0);
    chk("arst.tick_ball", int'(ball_x), 316);
    frame_tick = 1'b0;
    rst = 1'b0;
    m_reset();
    cyc(1'b0, 1'b0, 1'b0);
    chk_model("arst_rel");

    // Randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
